// File: rtl/score_inc_scheduler.sv
// Buffers multi-point score requests per requester and drains them into a BCD
// counter one point per cycle, round-robin; also sequences the counter's clear.
module score_inc_scheduler #(
   parameter int NREQ    = 4,
   parameter int PTS_W   = 4,
   parameter int PEND_W  = 6,
   parameter int CLR_CYC = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clear,
   input  logic                    i_pause,
   input  logic [NREQ-1:0]         i_req_valid,
   input  logic [NREQ*PTS_W-1:0]   i_req_pts,
   output logic [NREQ-1:0]         o_req_ready,
   output logic                    o_cnt_inc,
   output logic                    o_cnt_rstn,
   output logic [$clog2(NREQ)-1:0] o_grant_id,
   output logic                    o_busy
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int SUM_W = PEND_W + 1;
   localparam int CNT_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
   localparam logic [PEND_W-1:0] RDY_MAX  = PEND_W'((2**PEND_W - 1) - (2**PTS_W - 1));
   localparam logic [CNT_W-1:0]  CLR_LAST = CNT_W'(CLR_CYC - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_clr_cnt;
   logic [PEND_W-1:0] r_pend [NREQ];
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_grant_id;
   logic              r_cnt_inc;
   logic              r_cnt_rstn;

   logic [NREQ-1:0]   w_ready;
   logic              w_busy;
   logic              w_found;
   logic              w_grant;
   logic [ID_W-1:0]   w_idx;
   logic [ID_W-1:0]   w_gnt_idx;
   logic [ID_W-1:0]   w_rr_nxt;
   logic [SUM_W-1:0]  w_pend_nxt [NREQ];

   // Guard against a carry out of the widened sum; the ready threshold keeps it clear
   function automatic logic [PEND_W-1:0] clip_pend(input logic [SUM_W-1:0] v);
      clip_pend = v[PEND_W] ? {PEND_W{1'b1}} : v[PEND_W-1:0];
   endfunction

   // Ready and busy status derived from the accumulators
   always_comb begin
      w_ready = {NREQ{1'b0}};
      w_busy  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         w_ready[i] = (r_state == S_RUN) && (r_pend[i] <= RDY_MAX);
         w_busy     = w_busy | (r_pend[i] != {PEND_W{1'b0}});
      end
   end

   // Round-robin search for the first non-empty accumulator from r_rr_ptr
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = r_rr_ptr;
      w_idx     = r_rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = ID_W'((int'(r_rr_ptr) + k) % NREQ);
         if (!w_found && (r_pend[w_idx] != {PEND_W{1'b0}})) begin
            w_found   = 1'b1;
            w_gnt_idx = w_idx;
         end else begin
            w_found   = w_found;
         end
      end
      w_grant  = w_found && (r_state == S_RUN) && !i_pause;
      w_rr_nxt = (w_gnt_idx == ID_W'(NREQ - 1)) ? {ID_W{1'b0}} : (w_gnt_idx + ID_W'(1));
   end

   // Accumulator next values: add accepted points, remove the granted point
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_pend_nxt[i] = {1'b0, r_pend[i]};
         if (i_req_valid[i] && w_ready[i]) begin
            w_pend_nxt[i] = w_pend_nxt[i] + SUM_W'(i_req_pts[i*PTS_W +: PTS_W]);
         end else begin
            w_pend_nxt[i] = w_pend_nxt[i];
         end
         if (w_grant && (w_gnt_idx == ID_W'(i))) begin
            w_pend_nxt[i] = w_pend_nxt[i] - {{PEND_W{1'b0}}, 1'b1};
         end else begin
            w_pend_nxt[i] = w_pend_nxt[i];
         end
      end
   end

   // Clear/run sequencer, accumulators and registered counter controls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_CLEAR;
         r_clr_cnt  <= {CNT_W{1'b0}};
         r_rr_ptr   <= {ID_W{1'b0}};
         r_grant_id <= {ID_W{1'b0}};
         r_cnt_inc  <= 1'b0;
         r_cnt_rstn <= 1'b0;
         for (int i = 0; i < NREQ; i++) r_pend[i] <= {PEND_W{1'b0}};
      end else if (i_clear) begin
         r_state    <= S_CLEAR;
         r_clr_cnt  <= {CNT_W{1'b0}};
         r_cnt_inc  <= 1'b0;
         r_cnt_rstn <= 1'b0;
         for (int i = 0; i < NREQ; i++) r_pend[i] <= {PEND_W{1'b0}};
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_cnt_inc <= 1'b0;
               for (int i = 0; i < NREQ; i++) r_pend[i] <= {PEND_W{1'b0}};
               if (r_clr_cnt == CLR_LAST) begin
                  r_state    <= S_RUN;
                  r_clr_cnt  <= {CNT_W{1'b0}};
                  r_cnt_rstn <= 1'b1;
               end else begin
                  r_clr_cnt  <= r_clr_cnt + CNT_W'(1);
                  r_cnt_rstn <= 1'b0;
               end
            end
            S_RUN: begin
               r_cnt_rstn <= 1'b1;
               r_cnt_inc  <= w_grant;
               for (int i = 0; i < NREQ; i++) r_pend[i] <= clip_pend(w_pend_nxt[i]);
               if (w_grant) begin
                  r_grant_id <= w_gnt_idx;
                  r_rr_ptr   <= w_rr_nxt;
               end else begin
                  r_grant_id <= r_grant_id;
                  r_rr_ptr   <= r_rr_ptr;
               end
            end
            default: begin
               r_state    <= S_CLEAR;
               r_clr_cnt  <= {CNT_W{1'b0}};
               r_cnt_inc  <= 1'b0;
               r_cnt_rstn <= 1'b0;
               for (int i = 0; i < NREQ; i++) r_pend[i] <= {PEND_W{1'b0}};
            end
         endcase
      end
   end

   assign o_req_ready = w_ready;
   assign o_busy      = w_busy;
   assign o_cnt_inc   = r_cnt_inc;
   assign o_cnt_rstn  = r_cnt_rstn;
   assign o_grant_id  = r_grant_id;

endmodule

// File: tb/tb_score_inc_scheduler.sv
// Self-checking bench for score_inc_scheduler: directed scenarios plus randomized
// traffic, compared cycle by cycle against a point-counting reference model.
module tb_score_inc_scheduler;
   localparam int NREQ    = 4;
   localparam int PTS_W   = 4;
   localparam int PEND_W  = 6;
   localparam int CLR_CYC = 2;
   localparam int RDY_MAX = (2**PEND_W - 1) - (2**PTS_W - 1);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  clear;
   logic                  pause;
   logic [NREQ-1:0]       valid;
   logic [NREQ*PTS_W-1:0] pts;
   logic [NREQ-1:0]       ready;
   logic                  inc;
   logic                  rstn;
   logic [1:0]            gid;
   logic                  busy;

   int errors = 0;
   int checks = 0;

   // reference model state
   int m_pend [NREQ];
   int m_rr, m_gid, m_clr_left;
   bit m_inc, m_rstn;

   // observed DUT pulses
   int d_pulses [NREQ];
   int d_seq [$];

   score_inc_scheduler #(.NREQ(NREQ), .PTS_W(PTS_W), .PEND_W(PEND_W), .CLR_CYC(CLR_CYC)) dut (
      .clk(clk), .rst(rst), .i_clear(clear), .i_pause(pause),
      .i_req_valid(valid), .i_req_pts(pts), .o_req_ready(ready),
      .o_cnt_inc(inc), .o_cnt_rstn(rstn), .o_grant_id(gid), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) m_pend[i] = 0;
      m_rr = 0; m_gid = 0; m_clr_left = CLR_CYC; m_inc = 0; m_rstn = 0;
   endtask

   function automatic logic [8:0] exp_vec();
      logic [3:0] r;
      logic b;
      b = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         r[i] = (m_clr_left == 0) && (m_pend[i] <= RDY_MAX);
         b = b | (m_pend[i] != 0);
      end
      return {m_inc, 2'(m_gid), b, m_rstn, r};
   endfunction

   function automatic logic [8:0] act_vec();
      return {inc, gid, busy, rstn, ready};
   endfunction

   task automatic clear_counts();
      for (int i = 0; i < NREQ; i++) d_pulses[i] = 0;
      d_seq.delete();
   endtask

   task automatic set_req(input int i, input int p);
      valid[i] = 1'b1;
      pts[i*PTS_W +: PTS_W] = PTS_W'(p);
   endtask

   // advance one clock: update the model from the current inputs, then observe
   task automatic step();
      bit acc [NREQ];
      int g;
      g = -1;
      for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
      if (rst) begin
         model_reset();
      end else if (clear) begin
         for (int i = 0; i < NREQ; i++) m_pend[i] = 0;
         m_clr_left = CLR_CYC; m_inc = 0; m_rstn = 0;
      end else if (m_clr_left > 0) begin
         m_clr_left--;
         m_rstn = (m_clr_left == 0);
         m_inc = 0;
      end else begin
         for (int i = 0; i < NREQ; i++) acc[i] = valid[i] && (m_pend[i] <= RDY_MAX);
         if (!pause) begin
            for (int k = 0; k < NREQ; k++) begin
               if (g < 0 && m_pend[(m_rr + k) % NREQ] > 0) g = (m_rr + k) % NREQ;
            end
         end
         for (int i = 0; i < NREQ; i++) if (acc[i]) m_pend[i] += int'(pts[i*PTS_W +: PTS_W]);
         m_inc = (g >= 0);
         if (g >= 0) begin
            m_pend[g]--;
            m_gid = g;
            m_rr = (g + 1) % NREQ;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) valid[i] = 1'b0;
      if (inc === 1'b1) begin
         d_pulses[gid]++;
         d_seq.push_back(int'(gid));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; pause = 1'b0; valid = '0; pts = '0;
      model_reset();
      #2;
      checks++;
      if (act_vec() !== 9'h000) begin
         errors++; $display("FAIL reset_vals actual=%b required=%b", act_vec(), 9'h000);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      step();
      checks++;
      if (rstn !== 1'b0 || act_vec() !== exp_vec()) begin
         errors++; $display("FAIL clear_cyc1 actual=%b required=%b", act_vec(), exp_vec());
      end
      step();
      checks++;
      if ({rstn, ready, inc} !== {1'b1, 4'hF, 1'b0}) begin
         errors++; $display("FAIL first_run actual rstn/ready/inc=%b required=%b", {rstn, ready, inc}, {1'b1, 4'hF, 1'b0});
      end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL idle_run actual=%b required=%b", act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_single();
      int first, last;
      first = -1; last = -1;
      clear_counts();
      set_req(0, 5);
      step();
      checks++;
      if (inc !== 1'b0 || act_vec() !== exp_vec()) begin
         errors++; $display("FAIL single_accept actual=%b required=%b", act_vec(), exp_vec());
      end
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL single_cyc%0d actual=%b required=%b", c, act_vec(), exp_vec());
         end
         if (inc === 1'b1 && first < 0) first = c;
         if (inc === 1'b1) last = c;
      end
      checks++;
      if (d_pulses[0] !== 5 || first !== 0 || last !== 4) begin
         errors++; $display("FAIL single_pulses actual cnt=%0d first=%0d last=%0d required 5/0/4", d_pulses[0], first, last);
      end
   endtask

   task automatic test_back_to_back();
      int exp_seq [6];
      exp_seq = '{1, 3, 1, 3, 1, 3};
      clear_counts();
      set_req(1, 3);
      set_req(3, 3);
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL rr_cyc%0d actual=%b required=%b", c, act_vec(), exp_vec());
         end
      end
      checks++;
      if (d_seq.size() != 6) begin
         errors++; $display("FAIL rr_count actual=%0d required=6", d_seq.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++;
            if (d_seq[k] != exp_seq[k]) begin
               errors++; $display("FAIL rr_seq%0d actual=%0d required=%0d", k, d_seq[k], exp_seq[k]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      int fill [4];
      int acc_it;
      fill = '{15, 15, 15, 3};
      acc_it = -1;
      clear_counts();
      pause = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_req(2, fill[k]);
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL fill%0d actual=%b required=%b", k, act_vec(), exp_vec());
         end
      end
      checks++;
      if (ready[2] !== 1'b1) begin
         errors++; $display("FAIL ready_at_48 actual=%b required=1", ready[2]);
      end
      pause = 1'b0;
      set_req(2, 15);
      step();
      checks++;
      if ({ready[2], inc, valid[2]} !== 3'b010 || act_vec() !== exp_vec()) begin
         errors++; $display("FAIL accept_at_48 actual=%b required=%b", act_vec(), exp_vec());
      end
      set_req(2, 15);
      for (int c = 0; c < 95; c++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL ovf_cyc%0d actual=%b required=%b", c, act_vec(), exp_vec());
         end
         if (acc_it < 0 && valid[2] === 1'b0) acc_it = c;
      end
      checks++;
      if (acc_it !== 14 || d_pulses[2] !== 78 || busy !== 1'b0) begin
         errors++; $display("FAIL ovf_drain actual wait=%0d pulses=%0d busy=%b required 14/78/0", acc_it, d_pulses[2], busy);
      end
   endtask

   task automatic test_pause();
      clear_counts();
      set_req(1, 10);
      for (int c = 0; c < 4; c++) step();
      pause = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++;
         if (inc !== 1'b0 || act_vec() !== exp_vec()) begin
            errors++; $display("FAIL pause_cyc%0d actual=%b required=%b", c, act_vec(), exp_vec());
         end
      end
      pause = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL unpause_cyc%0d actual=%b required=%b", c, act_vec(), exp_vec());
         end
      end
      checks++;
      if (d_pulses[1] !== 10) begin
         errors++; $display("FAIL pause_total actual=%0d required=10", d_pulses[1]);
      end
   endtask

   task automatic test_clear();
      clear_counts();
      set_req(0, 7);
      step();
      for (int c = 0; c < 10 && d_pulses[0] < 3; c++) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if ({rstn, inc, busy} !== 3'b000 || act_vec() !== exp_vec()) begin
         errors++; $display("FAIL clear_edge actual=%b required=%b", act_vec(), exp_vec());
      end
      step();
      checks++;
      if ({rstn, inc, busy} !== 3'b000) begin
         errors++; $display("FAIL clear_hold actual rstn/inc/busy=%b required=000", {rstn, inc, busy});
      end
      step();
      checks++;
      if ({rstn, inc, busy} !== 3'b100 || act_vec() !== exp_vec()) begin
         errors++; $display("FAIL clear_exit actual=%b required=%b", act_vec(), exp_vec());
      end
      for (int c = 0; c < 4; c++) step();
      checks++;
      if (d_pulses[0] !== 3) begin
         errors++; $display("FAIL clear_drop actual=%0d required=3", d_pulses[0]);
      end
      clear_counts();
      set_req(0, 2);
      for (int c = 0; c < 8; c++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL post_clear_cyc%0d actual=%b required=%b", c, act_vec(), exp_vec());
         end
      end
      checks++;
      if (d_pulses[0] !== 2) begin
         errors++; $display("FAIL post_clear_total actual=%0d required=2", d_pulses[0]);
      end
   endtask

   task automatic test_async_reset();
      set_req(3, 9);
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (act_vec() !== 9'h000) begin
         errors++; $display("FAIL async_rst actual=%b required=%b", act_vec(), 9'h000);
      end
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      valid = '0;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL rst_release_cyc%0d actual=%b required=%b", c, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (valid[i] === 1'b0 && $urandom_range(0, 3) == 0) set_req(i, int'($urandom_range(0, 15)));
         end
         pause = ($urandom_range(0, 9) == 0);
         clear = ($urandom_range(0, 99) == 0);
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL rand_cyc%0d actual=%b required=%b", c, act_vec(), exp_vec());
         end
      end
      pause = 1'b0;
      clear = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_pause();
      test_clear();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
